// File: rtl/snoop_bus_ctrl_pkg.sv
// rtl/snoop_bus_ctrl_pkg.sv - shared types and constants for the MSI snoop-bus controller
package snoop_bus_ctrl_pkg;

  localparam int NCORE = 2;
  localparam int AW    = 13;
  localparam int LW    = AW - 2;

  typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR, OP_INV} bus_op_t;

  localparam logic [1:0] DS_MEM  = 2'b00;
  localparam logic [1:0] DS_PEER = 2'b01;
  localparam logic [1:0] DS_NONE = 2'b11;

  typedef enum logic [2:0] {ST_IDLE, ST_SNOOP, ST_DECIDE, ST_PEER, ST_MEM, ST_INV} snoop_st_t;

  typedef enum logic {PERM_FREE, PERM_HELD} perm_st_t;

  function automatic logic [15:0] line_word(input logic [63:0] line, input logic [1:0] off);
    return line[{off, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/snoop_bus_ctrl_if.sv
// rtl/snoop_bus_ctrl_if.sv - request/snoop/memory bundle between the cores, memory and the snoop bus
interface snoop_bus_ctrl_if;
  import snoop_bus_ctrl_pkg::*;

  logic [NCORE-1:0]          read_miss;
  logic [NCORE-1:0]          write_miss;
  logic [NCORE-1:0]          invalidate;
  logic [NCORE-1:0][AW-1:0]  req_addr;
  logic [NCORE-1:0]          search_found;
  logic [NCORE-1:0][15:0]    peer_data;
  logic [NCORE-1:0]          dmem_req;
  logic                      mem_rdy;
  logic [63:0]               mem_rd_data;

  logic [NCORE-1:0]          grant;
  logic [NCORE-1:0]          cpu_search;
  logic [NCORE-1:0]          snoop_inv;
  logic [LW-1:0]             BOCI;
  logic [NCORE-1:0][1:0]     cpu_datasel;
  logic [NCORE-1:0][15:0]    other_proc_data;
  logic [15:0]               bus_data;
  logic [NCORE-1:0]          cpu_dmem_permission;
  logic                      mem_re;
  logic [LW-1:0]             mem_addr;

  modport master (
    output read_miss, write_miss, invalidate, req_addr, search_found, peer_data,
           dmem_req, mem_rdy, mem_rd_data,
    input  grant, cpu_search, snoop_inv, BOCI, cpu_datasel, other_proc_data,
           bus_data, cpu_dmem_permission, mem_re, mem_addr
  );

  modport slave (
    input  read_miss, write_miss, invalidate, req_addr, search_found, peer_data,
           dmem_req, mem_rdy, mem_rd_data,
    output grant, cpu_search, snoop_inv, BOCI, cpu_datasel, other_proc_data,
           bus_data, cpu_dmem_permission, mem_re, mem_addr
  );

endinterface

// File: rtl/snoop_bus_ctrl_rr_arb2.sv
// rtl/snoop_bus_ctrl_rr_arb2.sv - two-requester round-robin arbiter; pointer moves to the loser on i_adv
module rr_arb2
  import snoop_bus_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NCORE-1:0] i_req,
  input  logic             i_adv,
  input  logic             i_adv_id,
  output logic             o_valid,
  output logic             o_win
);

  logic r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (i_adv) begin
      r_ptr <= ~i_adv_id;
    end
  end

  assign o_valid = |i_req;
  assign o_win   = i_req[r_ptr] ? r_ptr : ~r_ptr;

endmodule

// File: rtl/snoop_bus_ctrl.sv
// rtl/snoop_bus_ctrl.sv - MSI snoop-bus responder: request FSM plus memory-port permission arbiter
module snoop_bus_ctrl
  import snoop_bus_ctrl_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  snoop_bus_ctrl_if.slave bus
);

  snoop_st_t     r_state, w_state_nxt;
  bus_op_t       r_op, w_win_op;
  logic          r_owner;
  logic [AW-1:0] r_addr;
  perm_st_t      r_perm_st, w_perm_nxt;
  logic          r_perm_id;

  logic [NCORE-1:0] w_req;
  logic w_fsm_valid, w_fsm_win, w_peer, w_grant, w_fire;
  logic w_perm_valid, w_perm_win, w_perm_take, w_perm_busy, w_req_held;

  assign w_req  = bus.read_miss | bus.write_miss | bus.invalidate;
  assign w_peer = ~r_owner;
  assign w_fire = w_grant & ~i_rst;

  rr_arb2 u_fsm_arb (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(w_req), .i_adv(w_fire), .i_adv_id(r_owner),
    .o_valid(w_fsm_valid), .o_win(w_fsm_win)
  );

  rr_arb2 u_perm_arb (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(bus.dmem_req), .i_adv(w_perm_take), .i_adv_id(w_perm_win),
    .o_valid(w_perm_valid), .o_win(w_perm_win)
  );

  always_comb begin
    w_win_op = OP_NONE;
    if (bus.invalidate[w_fsm_win])      w_win_op = OP_INV;
    else if (bus.write_miss[w_fsm_win]) w_win_op = OP_WR;
    else if (bus.read_miss[w_fsm_win])  w_win_op = OP_RD;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NONE;
      r_owner <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_fsm_valid) begin
        r_owner <= w_fsm_win;
        r_op    <= w_win_op;
        r_addr  <= bus.req_addr[w_fsm_win];
      end
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_grant             = 1'b0;
    bus.cpu_search      = '0;
    bus.snoop_inv       = '0;
    bus.BOCI            = '0;
    bus.cpu_datasel     = {DS_NONE, DS_NONE};
    bus.other_proc_data = '0;
    bus.bus_data        = '0;
    bus.mem_re          = 1'b0;
    bus.mem_addr        = '0;
    if (r_state != ST_IDLE) bus.BOCI = r_addr[LW-1:0];
    case (r_state)
      ST_IDLE: if (w_fsm_valid) w_state_nxt = ST_SNOOP;
      ST_SNOOP: begin
        bus.cpu_search[w_peer] = 1'b1;
        if (r_op == OP_INV || r_op == OP_WR) bus.snoop_inv[w_peer] = 1'b1;
        w_state_nxt = (r_op == OP_INV) ? ST_INV : ST_DECIDE;
      end
      ST_DECIDE: begin
        w_state_nxt = (r_op == OP_RD && bus.search_found[w_peer]) ? ST_PEER : ST_MEM;
      end
      ST_PEER: begin
        bus.cpu_datasel[r_owner]     = DS_PEER;
        bus.other_proc_data[r_owner] = bus.peer_data[w_peer];
        bus.bus_data                 = bus.peer_data[w_peer];
        w_grant                      = 1'b1;
        w_state_nxt                  = ST_IDLE;
      end
      ST_MEM: begin
        bus.mem_addr = r_addr[AW-1:2];
        // The memory port is shared with core evictions; wait for it to be released.
        if (!w_perm_busy) begin
          bus.mem_re = 1'b1;
          if (bus.mem_rdy) begin
            bus.cpu_datasel[r_owner] = DS_MEM;
            bus.bus_data             = line_word(bus.mem_rd_data, r_addr[1:0]);
            w_grant                  = 1'b1;
            w_state_nxt              = ST_IDLE;
          end
        end
      end
      ST_INV: begin
        bus.cpu_datasel[r_owner] = DS_NONE;
        w_grant                  = 1'b1;
        w_state_nxt              = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.grant = {r_owner, ~r_owner} & {NCORE{w_fire}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perm_st <= PERM_FREE;
      r_perm_id <= 1'b0;
    end else begin
      r_perm_st <= w_perm_nxt;
      if (w_perm_take) r_perm_id <= w_perm_win;
    end
  end

  always_comb begin
    w_perm_nxt  = r_perm_st;
    w_perm_take = 1'b0;
    case (r_perm_st)
      PERM_FREE: if (w_perm_valid && r_state != ST_MEM) begin
        w_perm_take = 1'b1;
        w_perm_nxt  = PERM_HELD;
      end
      PERM_HELD: if (!bus.dmem_req[r_perm_id]) w_perm_nxt = PERM_FREE;
      default:   w_perm_nxt = PERM_FREE;
    endcase
  end

  assign w_perm_busy             = (r_perm_st == PERM_HELD);
  assign bus.cpu_dmem_permission = {r_perm_id, ~r_perm_id} & {NCORE{w_perm_busy}};

  assign w_req_held = (r_op == OP_INV) ? bus.invalidate[r_owner] :
                      (r_op == OP_WR)  ? bus.write_miss[r_owner] : bus.read_miss[r_owner];

  a_req_held : assert property (@(posedge i_clk) disable iff (i_rst) (r_state != ST_IDLE) |-> w_req_held);

endmodule
